// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: latches a word and scans sel over 16 channels, DIV cycles each; MUX_SCAN_MSB_FIRST_EN selects descending order
module mux_scan_serializer #(
  parameter int DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] mux_in,
  output logic [3:0]  sel,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        ser_last,
  output logic        busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam logic [3:0] HOLD_MAX = 4'(DIV - 1);
`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam logic [3:0] FIRST_SEL = 4'd15;
  localparam logic [3:0] LAST_SEL = 4'd0;
`else
  localparam logic [3:0] FIRST_SEL = 4'd0;
  localparam logic [3:0] LAST_SEL = 4'd15;
`endif
  logic [0:0] state;
  logic [3:0] hold;
  logic [3:0] next_sel;
  always_comb begin
`ifdef MUX_SCAN_MSB_FIRST_EN
    next_sel = sel - 4'd1;
`else
    next_sel = sel + 4'd1;
`endif
    ser_valid = state == SCAN;
    busy = ser_valid;
    in_ready = !ser_valid;
    ser_last = ser_valid && sel == LAST_SEL;
    ser_out = ser_valid ? mux_in[sel] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mux_in <= '0;
      sel <= '0;
      hold <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        state <= SCAN;
        mux_in <= in_data;
        sel <= FIRST_SEL;
        hold <= '0;
      end
    end else if (hold == HOLD_MAX) begin
      hold <= '0;
      state <= sel == LAST_SEL ? IDLE : SCAN;
      sel <= sel == LAST_SEL ? 4'd0 : next_sel;
    end else begin
      hold <= hold + 4'd1;
    end
  end
endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer: vector table, random words and corner sequences against DIV=1 and DIV=3 instances
module tb_mux_scan_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid [2];
  logic [15:0] in_data [2];
  logic in_ready [2];
  logic [15:0] mux_in [2];
  logic [3:0] sel [2];
  logic ser_out [2];
  logic ser_valid [2];
  logic ser_last [2];
  logic busy [2];
  int checks = 0;
  int errors = 0;
  typedef struct {
    int i;
    logic [15:0] word;
  } vec_t;
  vec_t vecs [7];
  always #5 clk = ~clk;
  mux_scan_serializer #(.DIV(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .mux_in(mux_in[0]), .sel(sel[0]), .ser_out(ser_out[0]),
    .ser_valid(ser_valid[0]), .ser_last(ser_last[0]), .busy(busy[0])
  );
  mux_scan_serializer #(.DIV(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .mux_in(mux_in[1]), .sel(sel[1]), .ser_out(ser_out[1]),
    .ser_valid(ser_valid[1]), .ser_last(ser_last[1]), .busy(busy[1])
  );
  function automatic int dv(int i);
    return i == 0 ? 1 : 3;
  endfunction
  function automatic int chan_idx(int i, int k);
    return (k - 1) / dv(i);
  endfunction
  function automatic logic [3:0] exp_sel(int i, int k);
`ifdef MUX_SCAN_MSB_FIRST_EN
    return 4'(15 - chan_idx(i, k));
`else
    return 4'(chan_idx(i, k));
`endif
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, int i, int k, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got %0h want %0h", name, i, k, act, exp);
    end
  endtask
  task automatic chk_idle(int i, int k, logic [15:0] word);
    chk("in_ready", i, k, 16'(in_ready[i]), 16'd1);
    chk("busy", i, k, 16'(busy[i]), 16'd0);
    chk("ser_valid", i, k, 16'(ser_valid[i]), 16'd0);
    chk("ser_last", i, k, 16'(ser_last[i]), 16'd0);
    chk("ser_out", i, k, 16'(ser_out[i]), 16'd0);
    chk("sel", i, k, 16'(sel[i]), 16'd0);
    chk("mux_in", i, k, mux_in[i], word);
  endtask
  task automatic chk_cycle(int i, int k, logic [15:0] word);
    logic [3:0] s;
    s = exp_sel(i, k);
    chk("in_ready", i, k, 16'(in_ready[i]), 16'd0);
    chk("busy", i, k, 16'(busy[i]), 16'd1);
    chk("ser_valid", i, k, 16'(ser_valid[i]), 16'd1);
    chk("sel", i, k, 16'(sel[i]), 16'(s));
    chk("ser_out", i, k, 16'(ser_out[i]), 16'(word[s]));
    chk("ser_last", i, k, 16'(ser_last[i]), 16'(chan_idx(i, k) == 15));
    chk("mux_in", i, k, mux_in[i], word);
  endtask
  task automatic chk_word(int i, logic [15:0] word, bit noise);
    int n;
    n = 16 * dv(i);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) tick;
      chk_cycle(i, k, word);
      if (noise) begin
        in_data[i] = 16'($urandom);
        in_valid[i] = k < n ? 1'($urandom) : 1'b0;
      end
    end
  endtask
  task automatic accept(int i, logic [15:0] word);
    in_valid[i] = 1'b1;
    in_data[i] = word;
    tick;
    in_valid[i] = 1'b0;
  endtask
  task automatic run_word(int i, logic [15:0] word);
    accept(i, word);
    chk_word(i, word, 1'b1);
    tick;
    chk_idle(i, 16 * dv(i) + 1, word);
  endtask
  initial begin
    vecs[0] = '{0, 16'h0080};
    vecs[1] = '{0, 16'h2000};
    vecs[2] = '{1, 16'h0010};
    vecs[3] = '{0, 16'h8001};
    vecs[4] = '{1, 16'hFFFF};
    vecs[5] = '{0, 16'h0000};
    vecs[6] = '{1, 16'h8001};
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b1;
      in_data[i] = 16'hFFFF;
    end
    tick;
    tick;
    chk_idle(0, 0, 16'h0000);
    chk_idle(1, 0, 16'h0000);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    tick;
    chk_idle(0, 0, 16'h0000);
    chk_idle(1, 0, 16'h0000);
    for (int v = 0; v < 7; v++) run_word(vecs[v].i, vecs[v].word);
    in_valid[0] = 1'b1;
    in_data[0] = 16'h2000;
    tick;
    in_data[0] = 16'h8001;
    chk_word(0, 16'h2000, 1'b0);
    tick;
    chk_idle(0, 17, 16'h2000);
    tick;
    chk_word(0, 16'h8001, 1'b0);
    in_valid[0] = 1'b0;
    tick;
    chk_idle(0, 17, 16'h8001);
    for (int r = 0; r < 20; r++) run_word(int'($urandom_range(0, 1)), 16'($urandom));
    accept(1, 16'hABCD);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick;
      chk_cycle(1, k, 16'hABCD);
    end
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    tick;
    tick;
    chk_idle(0, 0, 16'h0000);
    chk_idle(1, 0, 16'h0000);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    tick;
    chk_idle(0, 1, 16'h0000);
    chk_idle(1, 1, 16'h0000);
    accept(0, 16'h0020);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick;
      chk_cycle(0, k, 16'h0020);
      if (exp_sel(0, k) == 4'd5) break;
    end
    rst = 1'b1;
    tick;
    chk_idle(0, 0, 16'h0000);
    rst = 1'b0;
    tick;
    chk_idle(0, 1, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
